// File: rtl/reg_read_port_if.sv
// -----------------------------------------------------------------------------
// reg_read_port_if
//
// Bundle of the decode, issue and write-back signals that meet at the
// register-file read side. The master modport belongs to whoever drives
// decode and write-back. The slave modport belongs to the register file.
//
// Signals (all synchronous to the register-file clock):
//   READENABLE   decode requests an operand read this cycle
//   ReadAddrA/B  source register addresses
//   ISSUE        decode issues an instruction that will write IssueDest
//   IssueDest    destination register of the issued instruction
//   WRITEENABLE  write-back valid
//   WriteAddr    write-back register address
//   WriteData    write-back value
//   ReadDataA/B  registered operands
//   READVALID    ReadDataA/B were updated at the last edge
//   STALL        combinational; the current read request cannot complete
// -----------------------------------------------------------------------------
interface reg_read_port_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5
);
    logic                 READENABLE;
    logic [ADDRWIDTH-1:0] ReadAddrA;
    logic [ADDRWIDTH-1:0] ReadAddrB;
    logic                 ISSUE;
    logic [ADDRWIDTH-1:0] IssueDest;
    logic                 WRITEENABLE;
    logic [ADDRWIDTH-1:0] WriteAddr;
    logic [DATAWIDTH-1:0] WriteData;
    logic [DATAWIDTH-1:0] ReadDataA;
    logic [DATAWIDTH-1:0] ReadDataB;
    logic                 READVALID;
    logic                 STALL;

    modport master (
        output READENABLE, ReadAddrA, ReadAddrB,
        output ISSUE, IssueDest,
        output WRITEENABLE, WriteAddr, WriteData,
        input  ReadDataA, ReadDataB, READVALID, STALL
    );

    modport slave (
        input  READENABLE, ReadAddrA, ReadAddrB,
        input  ISSUE, IssueDest,
        input  WRITEENABLE, WriteAddr, WriteData,
        output ReadDataA, ReadDataB, READVALID, STALL
    );
endinterface

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
//
// Read side of the register file. It holds 2**ADDRWIDTH registers of
// DATAWIDTH bits and has two registered read ports and one write-back port.
// A busy-bit scoreboard marks registers whose result has been issued but not
// yet written back. While a requested source is busy, STALL holds decode.
//
// Ports:
//   CLK      clock; all state updates on the rising edge
//   RESET_N  asynchronous, active-low reset. Clears storage, the busy bits
//            and the read outputs.
//   bus      reg_read_port_if.slave. It carries the read request, issue,
//            write-back, read data, READVALID and STALL.
//
// Register 0 is hard-wired to zero. It ignores writes and is never busy.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - a write-back in the same cycle as a read to the same register
//               is forwarded to that read port. It also resolves a busy
//               source, so there is no extra stall.
//   undefined - there is no forwarding. A same-cycle matching write-back is
//               treated as a hazard. The read then completes on the following
//               cycle from storage.
// -----------------------------------------------------------------------------
module reg_read_port #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    reg_read_port_if.slave    bus
);

    localparam int DEPTH = 1 << ADDRWIDTH;

    typedef logic [DATAWIDTH-1:0] word_t;

    // Architectural state
    word_t            regs_q [DEPTH];
    word_t            regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Read-port output registers
    word_t            rdata_a_q;
    word_t            rdata_a_d;
    word_t            rdata_b_q;
    word_t            rdata_b_d;
    logic             rvalid_q;
    logic             rvalid_d;

    // Request decode
    logic             src_a_nz;
    logic             src_b_nz;
    logic             wr_hit_a;
    logic             wr_hit_b;
    logic             hazard_a;
    logic             hazard_b;
    logic             stall;
    logic             accept;
    word_t            oper_a;
    word_t            oper_b;

    // -------------------------------------------------------------------------
    // Hazard detection and operand selection. Nothing here depends on ISSUE,
    // so STALL has no combinational path from the issue handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        src_a_nz = (bus.ReadAddrA != '0);
        src_b_nz = (bus.ReadAddrB != '0);
        wr_hit_a = bus.WRITEENABLE && (bus.WriteAddr == bus.ReadAddrA);
        wr_hit_b = bus.WRITEENABLE && (bus.WriteAddr == bus.ReadAddrB);

`ifdef REGFILE_BYPASS_EN
        // A matching write-back resolves a busy source in the same cycle.
        hazard_a = src_a_nz && busy_q[bus.ReadAddrA] && !wr_hit_a;
        hazard_b = src_b_nz && busy_q[bus.ReadAddrB] && !wr_hit_b;

        oper_a = '0;
        if (src_a_nz) begin
            oper_a = wr_hit_a ? bus.WriteData : regs_q[bus.ReadAddrA];
        end
        oper_b = '0;
        if (src_b_nz) begin
            oper_b = wr_hit_b ? bus.WriteData : regs_q[bus.ReadAddrB];
        end
`else
        // Without forwarding, a same-cycle matching write-back also holds the
        // read off. The next cycle then reads the freshly written value.
        hazard_a = src_a_nz && (busy_q[bus.ReadAddrA] || wr_hit_a);
        hazard_b = src_b_nz && (busy_q[bus.ReadAddrB] || wr_hit_b);

        oper_a = src_a_nz ? regs_q[bus.ReadAddrA] : '0;
        oper_b = src_b_nz ? regs_q[bus.ReadAddrB] : '0;
`endif

        // Reset clears the busy bits asynchronously. Gating with RESET_N also
        // keeps STALL low during the settling time of reset.
        stall  = RESET_N && bus.READENABLE && (hazard_a || hazard_b);
        accept = bus.READENABLE && !stall;
    end

    // -------------------------------------------------------------------------
    // Next state: storage write, scoreboard update and read capture
    // -------------------------------------------------------------------------
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        rvalid_d  = 1'b0;

        if (bus.WRITEENABLE && (bus.WriteAddr != '0)) begin
            regs_d[bus.WriteAddr] = bus.WriteData;
            busy_d[bus.WriteAddr] = 1'b0;
        end

        // This is applied after the write-back clear, so a set to the same
        // address wins.
        if (bus.ISSUE && !stall && (bus.IssueDest != '0)) begin
            busy_d[bus.IssueDest] = 1'b1;
        end

        if (accept) begin
            rdata_a_d = oper_a;
            rdata_b_d = oper_b;
            rvalid_d  = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            regs_q    <= '{default: '0};
            busy_q    <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus.ReadDataA = rdata_a_q;
    assign bus.ReadDataB = rdata_b_q;
    assign bus.READVALID = rvalid_q;
    assign bus.STALL     = stall;

endmodule

// File: tb/tb_reg_read_port.sv
// -----------------------------------------------------------------------------
// tb_reg_read_port
//
// Self-checking bench for reg_read_port. A behavioural model holds the
// register contents and the set of outstanding destinations as plain arrays.
// STALL is checked before each edge. READVALID, ReadDataA and ReadDataB are
// checked just after each edge. Directed scenarios run first, followed by a
// randomized run. Build with +define+REGFILE_BYPASS_EN to check the
// forwarding variant.
// -----------------------------------------------------------------------------
module tb_reg_read_port;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_read_port_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    reg_read_port #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [DW-1:0] m_regs [NREG];
    bit            m_pending [NREG];
    logic [DW-1:0] m_rd_a;
    logic [DW-1:0] m_rd_b;
    logic          m_valid;

    // Stimulus currently applied
    logic          s_re;
    int            s_a;
    int            s_b;
    logic          s_iss;
    int            s_dest;
    logic          s_we;
    int            s_wa;
    logic [DW-1:0] s_wd;

    function automatic bit bypass_on();
`ifdef REGFILE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i]    = '0;
            m_pending[i] = 1'b0;
        end
        m_rd_a  = '0;
        m_rd_b  = '0;
        m_valid = 1'b0;
    endtask

    // The operand cannot be delivered this cycle if its result is still
    // outstanding. Without forwarding, it also cannot be delivered if it is
    // being written back right now.
    function automatic bit blocked(input int r);
        bit wb_now;
        if (r == 0) return 1'b0;
        wb_now = s_we && (s_wa == r);
        if (bypass_on()) return m_pending[r] && !wb_now;
        return m_pending[r] || wb_now;
    endfunction

    function automatic logic [DW-1:0] value_of(input int r);
        if (r == 0) return '0;
        if (bypass_on() && s_we && (s_wa == r)) return s_wd;
        return m_regs[r];
    endfunction

    task automatic drive(input logic re, input int a, input int b,
                         input logic iss, input int dest,
                         input logic we, input int wa, input logic [DW-1:0] wd);
        s_re = re; s_a = a; s_b = b; s_iss = iss; s_dest = dest;
        s_we = we; s_wa = wa; s_wd = wd;
        bus.READENABLE  = re;
        bus.ReadAddrA   = AW'(a);
        bus.ReadAddrB   = AW'(b);
        bus.ISSUE       = iss;
        bus.IssueDest   = AW'(dest);
        bus.WRITEENABLE = we;
        bus.WriteAddr   = AW'(wa);
        bus.WriteData   = wd;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, '0);
    endtask

    // Call this 1 time unit after a rising edge with the inputs already
    // driven. It checks STALL, advances one edge, updates the model and
    // checks the registered outputs.
    task automatic tick(input string tag);
        bit exp_stall;
        bit acc;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        #3;
        exp_stall = s_re && (blocked(s_a) || blocked(s_b));
        chk({tag, ".stall"}, {31'b0, bus.STALL}, {31'b0, exp_stall});
        acc = s_re && !exp_stall;
        va  = value_of(s_a);
        vb  = value_of(s_b);
        @(posedge clk);
        if (acc) begin
            m_rd_a = va;
            m_rd_b = vb;
        end
        m_valid = acc;
        if (s_we && s_wa != 0) begin
            m_regs[s_wa]    = s_wd;
            m_pending[s_wa] = 1'b0;
        end
        if (s_iss && !exp_stall && s_dest != 0) m_pending[s_dest] = 1'b1;
        #1;
        chk({tag, ".valid"}, {31'b0, bus.READVALID}, {31'b0, m_valid});
        chk({tag, ".rda"}, bus.ReadDataA, m_rd_a);
        chk({tag, ".rdb"}, bus.ReadDataB, m_rd_b);
    endtask

    initial begin
        int cyc;
        model_reset();
        idle();

        // Reset state
        #2;
        chk("rst.rda", bus.ReadDataA, '0);
        chk("rst.rdb", bus.ReadDataB, '0);
        chk("rst.valid", {31'b0, bus.READVALID}, 32'd0);
        chk("rst.stall", {31'b0, bus.STALL}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Read r5 and r0 straight out of reset; both are zero
        drive(1'b1, 5, 0, 1'b0, 0, 1'b0, 0, '0);
        tick("rd5_0");
        idle();
        tick("rd5_0.after");

        // Write r7, then read it on both ports
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 32'h1234_5678);
        tick("wr7");
        drive(1'b1, 7, 7, 1'b0, 0, 1'b0, 0, '0);
        tick("rd77");
        chk("rd77.const", bus.ReadDataA, 32'h1234_5678);

        // r0 ignores writes and issues
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 32'hFFFF_FFFF);
        tick("wr0");
        drive(1'b1, 0, 7, 1'b1, 0, 1'b0, 0, '0);
        tick("iss0_rd0");
        chk("rd0.const", bus.ReadDataA, 32'h0);

        // Issue r3. The r3 read waits for write-back of 0xAA.
        drive(1'b0, 0, 0, 1'b1, 3, 1'b0, 0, '0);
        tick("iss3");
        drive(1'b1, 3, 0, 1'b0, 0, 1'b0, 0, '0);
        tick("rd3.c1");
        tick("rd3.c2");
        drive(1'b1, 3, 0, 1'b0, 0, 1'b1, 3, 32'hAA);
        tick("rd3.c3");
        if (!bypass_on()) begin
            drive(1'b1, 3, 0, 1'b0, 0, 1'b0, 0, '0);
            tick("rd3.c4");
        end
        chk("rd3.const", bus.ReadDataA, 32'hAA);
        idle();
        tick("rd3.idle");

        // Same-cycle issue and write-back to r9: the set wins, so r9 stays busy
        drive(1'b0, 0, 0, 1'b1, 9, 1'b1, 9, 32'h55);
        tick("iss9_wb9");
        drive(1'b1, 9, 0, 1'b0, 0, 1'b0, 0, '0);
        tick("rd9.busy");
        chk("rd9.stall.const", {31'b0, bus.STALL}, 32'd1);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 9, 32'h77);
        tick("wb9");
        drive(1'b1, 9, 9, 1'b0, 0, 1'b0, 0, '0);
        tick("rd9.done");

        // Reset asserted while a read of busy r4 is stalled
        drive(1'b0, 0, 0, 1'b1, 4, 1'b0, 0, '0);
        tick("iss4");
        drive(1'b1, 4, 0, 1'b0, 0, 1'b0, 0, '0);
        #2;
        chk("rst4.stall_before", {31'b0, bus.STALL}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst4.stall", {31'b0, bus.STALL}, 32'd0);
        chk("rst4.rda", bus.ReadDataA, '0);
        chk("rst4.valid", {31'b0, bus.READVALID}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 4, 0, 1'b0, 0, 1'b0, 0, '0);
        tick("rst4.rd");

        // Randomized traffic. Small address range so hazards, matching
        // write-backs and issues collide often.
        cyc = 0;
        repeat (400) begin
            drive(($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  ($urandom_range(0, 1) == 0), $urandom_range(0, 7),
                  $urandom);
            tick($sformatf("rnd%0d", cyc));
            cyc++;
        end

        idle();
        tick("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
